// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding, button indices and defaults for the stopwatch control block
// Contents:
//   sw_state_t        FSM state encoding (IDLE=0, RUN=1, PAUSE=2)
//   BTN_*             bit index of each button inside btn_raw
//   *_DEFAULT         default parameter values for the control block
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    localparam int BTN_CLEAR = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_LAP   = 2;
    localparam int BTN_START = 3;

    localparam int DEBOUNCE_DEFAULT  = 16;
    localparam int TICK_DIV_DEFAULT  = 1200000;
    localparam int LAP_TICKS_DEFAULT = 20;

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// rtl/stopwatch_ctrl_btn_debounce.sv - one-button synchronizer, debouncer and press-pulse generator
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   i_raw    in   raw active-high button level (asynchronous)
//   o_press  out  one-cycle pulse on each accepted press
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_q;
    logic          r_armed;
    logic          r_press;
    logic [1:0]    r_fill;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_armed   <= 1'b0;
            r_press   <= 1'b0;
            r_fill    <= 2'b00;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_fill    <= {r_fill[0], 1'b1};
            r_level_q <= r_level;

            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end

            // Arm only after a genuine released level has passed through the
            // synchronizer, so a button held across reset never fires.
            if (r_fill[1] && !r_sync2 && !r_level) begin
                r_armed <= 1'b1;
            end

            r_press <= r_armed && r_level && !r_level_q;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run/pause/idle control, timebase divider and lap-hold window
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   btn_raw    in   raw buttons: [0] clear, [1] stop, [2] lap, [3] start
//   tick       out  one-cycle free-running timebase pulse
//   cnt_en     out  one-cycle BCD counter increment strobe
//   cnt_clear  out  one-cycle BCD counter clear strobe
//   lap_load   out  one-cycle lap register capture strobe
//   show_lap   out  display shows the lap register while high
//   state      out  FSM state (0 IDLE, 1 RUN, 2 PAUSE)
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int TICK_DIV        = TICK_DIV_DEFAULT,
    parameter int LAP_TICKS       = LAP_TICKS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    output logic       tick,
    output logic       cnt_en,
    output logic       cnt_clear,
    output logic       lap_load,
    output logic       show_lap,
    output logic [1:0] state
);

    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [4:0] LAP_RELOAD = 5'(LAP_TICKS);

    logic [3:0] w_press;

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_raw  (btn_raw[g]),
            .o_press(w_press[g])
        );
    end

    sw_state_t     r_state;
    logic [DW-1:0] r_div;
    logic [4:0]    r_lap_rem;
    logic          r_tick;
    logic          r_cnt_en;
    logic          r_cnt_clear;
    logic          r_lap_load;
    logic          r_show_lap;

    // Fixed priority clear > stop > start > lap; losers are simply dropped.
    logic w_clr;
    logic w_stop;
    logic w_start;
    logic w_lap;
    assign w_clr   = w_press[BTN_CLEAR];
    assign w_stop  = w_press[BTN_STOP] && !w_press[BTN_CLEAR];
    assign w_start = w_press[BTN_START] && !w_press[BTN_CLEAR] && !w_press[BTN_STOP];
    assign w_lap   = w_press[BTN_LAP] && !w_press[BTN_CLEAR] && !w_press[BTN_STOP]
                     && !w_press[BTN_START];

    logic w_stop_acc;
    logic w_div_reset;
    logic w_lap_acc;
    assign w_stop_acc  = w_stop && (r_state == ST_RUN);
    assign w_div_reset = w_clr || (w_start && (r_state == ST_IDLE));
    assign w_lap_acc   = w_lap && (r_state != ST_IDLE);

    logic [4:0] w_lap_next;
    always_comb begin
        w_lap_next = r_lap_rem;
        if (w_clr) begin
            w_lap_next = '0;
        end else if (w_lap_acc) begin
            w_lap_next = LAP_RELOAD;
        end else if (r_tick && (r_lap_rem != 5'd0)) begin
            w_lap_next = r_lap_rem - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_div       <= '0;
            r_lap_rem   <= '0;
            r_tick      <= 1'b0;
            r_cnt_en    <= 1'b0;
            r_cnt_clear <= 1'b0;
            r_lap_load  <= 1'b0;
            r_show_lap  <= 1'b0;
        end else begin
            // A forced restart also swallows a tick that would land on the
            // same edge, so the first increment is a full period away.
            if (w_div_reset) begin
                r_div  <= '0;
                r_tick <= 1'b0;
            end else if (r_div == DIV_LAST) begin
                r_div  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_div  <= r_div + 1'b1;
                r_tick <= 1'b0;
            end

            r_cnt_en    <= r_tick && (r_state == ST_RUN) && !w_clr && !w_stop_acc;
            r_cnt_clear <= w_clr;
            r_lap_load  <= w_lap_acc;
            r_lap_rem   <= w_lap_next;
            r_show_lap  <= (w_lap_next != 5'd0);

            if (w_clr) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE:  if (w_start) r_state <= ST_RUN;
                    ST_RUN:   if (w_stop)  r_state <= ST_PAUSE;
                    ST_PAUSE: if (w_start) r_state <= ST_RUN;
                    default:               r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign tick      = r_tick;
    assign cnt_en    = r_cnt_en;
    assign cnt_clear = r_cnt_clear;
    assign lap_load  = r_lap_load;
    assign show_lap  = r_show_lap;
    assign state     = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

    localparam int DB = 4;
    localparam int TD = 10;
    localparam int LT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_raw = 4'b0000;
    logic       tick;
    logic       cnt_en;
    logic       cnt_clear;
    logic       lap_load;
    logic       show_lap;
    logic [1:0] state;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_DIV       (TD),
        .LAP_TICKS      (LT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .tick     (tick),
        .cnt_en   (cnt_en),
        .cnt_clear(cnt_clear),
        .lap_load (lap_load),
        .show_lap (show_lap),
        .state    (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Expected strobe cycles and divider restart points, pushed as stimulus is driven.
    int en_q[$];
    int lap_q[$];
    int clr_q[$];
    int base_q[$];
    int div_base = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit exp_tick;
        while (base_q.size() > 0 && base_q[0] <= cyc) div_base = base_q.pop_front();
        exp_tick = (cyc > div_base) && (((cyc - div_base) % TD) == 0);
        if (tick || exp_tick) check_eq("tick", int'(tick), int'(exp_tick));
        if (cnt_en) begin
            if (en_q.size() == 0) check_eq("cnt_en_unexpected", cyc, -1);
            else check_eq("cnt_en_cycle", cyc, en_q.pop_front());
        end
        if (lap_load) begin
            if (lap_q.size() == 0) check_eq("lap_load_unexpected", cyc, -1);
            else check_eq("lap_load_cycle", cyc, lap_q.pop_front());
        end
        if (cnt_clear) begin
            if (clr_q.size() == 0) check_eq("cnt_clear_unexpected", cyc, -1);
            else check_eq("cnt_clear_cycle", cyc, clr_q.pop_front());
        end
    end

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_state"}, int'(state), 0);
        check_eq({tag, "_tick"}, int'(tick), 0);
        check_eq({tag, "_cnt_en"}, int'(cnt_en), 0);
        check_eq({tag, "_cnt_clear"}, int'(cnt_clear), 0);
        check_eq({tag, "_lap_load"}, int'(lap_load), 0);
        check_eq({tag, "_show_lap"}, int'(show_lap), 0);
    endtask

    initial begin
        int c;
        c = 10;
        base_q.push_back(3);
        wait_until(3);
        check_all_zero("reset");
        rst_n = 1'b1;

        // start press, held 20 cycles
        wait_until(c);
        btn_raw[3] = 1'b1;
        base_q.push_back(c + 8);
        en_q.push_back(c + 19);
        en_q.push_back(c + 29);
        wait_until(c + 7);  check_eq("t1_idle_before_press", int'(state), 0);
        wait_until(c + 8);  check_eq("t1_run", int'(state), 1);
        wait_until(c + 20); btn_raw[3] = 1'b0;

        // stop accepted on the edge right after a tick: that tick must not count
        wait_until(c + 31); btn_raw[1] = 1'b1;
        wait_until(c + 38); check_eq("t3_still_run", int'(state), 1);
        wait_until(c + 39); check_eq("t3_pause", int'(state), 2);
        wait_until(c + 41); btn_raw[1] = 1'b0;

        // resume keeps divider phase
        wait_until(c + 45);
        btn_raw[3] = 1'b1;
        for (int k = 59; k <= 119; k += 10) en_q.push_back(c + k);
        wait_until(c + 52); check_eq("t3_pause_hold", int'(state), 2);
        wait_until(c + 53); check_eq("t3_resume", int'(state), 1);
        btn_raw[3] = 1'b0;

        // lap window and reload
        wait_until(c + 62); btn_raw[2] = 1'b1; lap_q.push_back(c + 70);
        wait_until(c + 67); btn_raw[2] = 1'b0;
        wait_until(c + 69); check_eq("t4_show_before", int'(show_lap), 0);
        wait_until(c + 70); check_eq("t4_show_on", int'(show_lap), 1);
        wait_until(c + 82); btn_raw[2] = 1'b1; lap_q.push_back(c + 90);
        wait_until(c + 87); btn_raw[2] = 1'b0;
        wait_until(c + 99); check_eq("t4_show_reloaded", int'(show_lap), 1);
        wait_until(c + 115); btn_raw[2] = 1'b1; lap_q.push_back(c + 123);
        wait_until(c + 118); check_eq("t4_show_last_tick", int'(show_lap), 1);
        wait_until(c + 119); check_eq("t4_show_expired", int'(show_lap), 0);
        wait_until(c + 120); btn_raw[2] = 1'b0;

        // clear, stop and start together: clear wins
        wait_until(c + 121);
        btn_raw = 4'b1011;
        clr_q.push_back(c + 129);
        base_q.push_back(c + 129);
        wait_until(c + 126); btn_raw = 4'b0000;
        wait_until(c + 128);
        check_eq("t5_show_before_clear", int'(show_lap), 1);
        check_eq("t5_run_before_clear", int'(state), 1);
        wait_until(c + 129);
        check_eq("t5_idle", int'(state), 0);
        check_eq("t5_show_cleared", int'(show_lap), 0);
        wait_until(c + 135); check_eq("t5_idle_later", int'(state), 0);

        // reset while running with show_lap high, button held through reset
        wait_until(c + 140);
        btn_raw[3] = 1'b1;
        base_q.push_back(c + 148);
        en_q.push_back(c + 159);
        wait_until(c + 145); btn_raw[3] = 1'b0;
        wait_until(c + 148); check_eq("t6_run", int'(state), 1);
        wait_until(c + 150); btn_raw[2] = 1'b1; lap_q.push_back(c + 158);
        wait_until(c + 155); btn_raw[2] = 1'b0;
        wait_until(c + 160); btn_raw[3] = 1'b1; base_q.push_back(c + 166);
        wait_until(c + 165);
        check_eq("t6_show_pre_reset", int'(show_lap), 1);
        check_eq("t6_run_pre_reset", int'(state), 1);
        rst_n = 1'b0;
        wait_until(c + 166);
        rst_n = 1'b1;
        check_all_zero("t6_after_reset");
        wait_until(c + 190);
        check_eq("t6_held_no_press", int'(state), 0);
        btn_raw[3] = 1'b0;

        // bouncing re-press: one press, latency counted from the stable level
        wait_until(c + 200);
        btn_raw[3] = 1'b1;
        base_q.push_back(c + 212);
        en_q.push_back(c + 223);
        wait_until(c + 201); btn_raw[3] = 1'b0;
        wait_until(c + 202); btn_raw[3] = 1'b1;
        wait_until(c + 203); btn_raw[3] = 1'b0;
        wait_until(c + 204); btn_raw[3] = 1'b1;
        wait_until(c + 211); check_eq("t2_idle_during_bounce", int'(state), 0);
        wait_until(c + 212); check_eq("t2_run", int'(state), 1);

        wait_until(c + 226);
        check_eq("pending_cnt_en", en_q.size(), 0);
        check_eq("pending_lap_load", lap_q.size(), 0);
        check_eq("pending_cnt_clear", clr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
